// File: rtl/telemetry_if.sv
// Telemetry link bundle: readings + request strobe in, UART line and status out.
interface telemetry_if;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
    logic        vld;
    logic        TX;
    logic        busy;
    logic        frame_done;

    modport master (output batt, curr, torque, vld, input TX, busy, frame_done);
    modport slave  (input batt, curr, torque, vld, output TX, busy, frame_done);
endinterface

// File: rtl/telemetry_tx.sv
// Snapshots battery/current/torque on vld and sends a 9-byte framed packet as UART 8N1.
// state   | meaning
// IDLE    | line high, waiting for vld
// START   | start bit (0) of the current byte
// DATA    | 8 data bits, LSB first
// STOP    | stop bit (1); then next byte or end of frame
module telemetry_tx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    telemetry_if.slave  tlm
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    logic [1:0]  state_q,    state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  shift_q,    shift_d;
    logic [35:0] shadow_q,   shadow_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        tx_q,       tx_d;
    logic [7:0]  chk;
    logic        baud_end;

    // shadow layout: {batt, curr, torque}
    assign chk = {4'h0, shadow_q[35:32] ^ shadow_q[23:20] ^ shadow_q[11:8]}
               ^ shadow_q[31:24] ^ shadow_q[19:12] ^ shadow_q[7:0];
    assign baud_end = (baud_cnt_q == 16'd0);

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [35:0] sh,
                                              input logic [7:0] c);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hAA;
            4'd1:    b = 8'h55;
            4'd2:    b = {4'h0, sh[35:32]};
            4'd3:    b = sh[31:24];
            4'd4:    b = {4'h0, sh[23:20]};
            4'd5:    b = sh[19:12];
            4'd6:    b = {4'h0, sh[11:8]};
            4'd7:    b = sh[7:0];
            default: b = c;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tlm.vld && !busy_q) begin
                    state_d    = S_START;
                    busy_d     = 1'b1;
                    baud_cnt_d = BAUD_RELOAD;
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 4'd0;
                    shadow_d   = {tlm.batt, tlm.curr, tlm.torque};
                    shift_d    = 8'hAA;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d    = S_DATA;
                    baud_cnt_d = BAUD_RELOAD;
                    bit_cnt_d  = 3'd0;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                if (baud_end) begin
                    if (byte_idx_q == 4'd8) begin
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        baud_cnt_d = 16'd0;
                    end else begin
                        state_d    = S_START;
                        baud_cnt_d = BAUD_RELOAD;
                        byte_idx_d = byte_idx_q + 4'd1;
                        shift_d    = frame_byte(byte_idx_q + 4'd1, shadow_q, chk);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
        endcase
        // TX is registered from the next state so the line never glitches on decode.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 4'd0;
            shift_q    <= 8'd0;
            shadow_q   <= 36'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
        end
    end

    assign tlm.TX         = tx_q;
    assign tlm.busy       = busy_q;
    assign tlm.frame_done = done_q;
endmodule

// File: tb/tb_telemetry_tx.sv
// Directed bench for telemetry_tx with BAUD_DIV=16: mid-bit sampling of TX at fixed offsets.
module tb_telemetry_tx;
    localparam int BD    = 16;
    localparam int FRAME = 90 * BD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    telemetry_if tlm ();

    telemetry_tx #(.BAUD_DIV(BD)) dut (.clk(clk), .rst(rst), .tlm(tlm));

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] rx_b [9];
    int   busy_n, done_c, done_n, frame_errs;
    logic tx_first, tx_last;

    // Assumes vld and the readings are already driven; the next posedge accepts (c=0).
    task automatic run_frame(input int poke_cyc);
        logic bits [90];
        @(posedge clk); #1; tlm.vld = 1'b0;
        busy_n = 0; done_c = -1; done_n = 0; frame_errs = 0;
        for (int c = 0; c <= FRAME; c++) begin
            if (c > 0) begin @(posedge clk); #1; tlm.vld = 1'b0; end
            if (c == 0) tx_first = tlm.TX;
            if (c == FRAME) tx_last = tlm.TX;
            if (c < FRAME && (c % BD) == BD / 2) bits[c / BD] = tlm.TX;
            if (tlm.busy === 1'b1) busy_n++;
            if (tlm.frame_done === 1'b1) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (c == poke_cyc) begin tlm.batt = 12'd100; tlm.vld = 1'b1; end
        end
        for (int n = 0; n < 9; n++) begin
            if (bits[n*10] !== 1'b0) frame_errs++;
            if (bits[n*10+9] !== 1'b1) frame_errs++;
            for (int k = 0; k < 8; k++) rx_b[n][k] = bits[n*10+1+k];
        end
    endtask

    task automatic start_inputs(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        tlm.batt = b; tlm.curr = c; tlm.torque = t; tlm.vld = 1'b1;
    endtask

    task automatic test_reset;
        int bad_tx, bad_busy, bad_done;
        n_total++;
        if (tlm.TX !== 1'b1 || tlm.busy !== 1'b0 || tlm.frame_done !== 1'b0)
            $display("FAIL reset_values: TX=%b busy=%b done=%b, want 1 0 0", tlm.TX, tlm.busy, tlm.frame_done);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        bad_tx = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tlm.TX !== 1'b1) bad_tx++;
            if (tlm.busy !== 1'b0) bad_busy++;
            if (tlm.frame_done !== 1'b0) bad_done++;
        end
        n_total++;
        if (bad_tx != 0) $display("FAIL idle_tx: %0d cycles not high, want 0", bad_tx); else n_pass++;
        n_total++;
        if (bad_busy != 0) $display("FAIL idle_busy: %0d cycles busy, want 0", bad_busy); else n_pass++;
        n_total++;
        if (bad_done != 0) $display("FAIL idle_done: %0d pulses, want 0", bad_done); else n_pass++;
    endtask

    task automatic test_basic_frame;
        logic [7:0] exp_b [9] = '{8'hAA, 8'h55, 8'h0B, 8'h11, 8'h02, 8'h34, 8'h06, 8'h00, 8'h2A};
        @(negedge clk); start_inputs(12'hB11, 12'h234, 12'h600);
        run_frame(-1);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rx_b[i] !== exp_b[i]) $display("FAIL basic_byte%0d: got %h want %h", i, rx_b[i], exp_b[i]);
            else n_pass++;
        end
        n_total++;
        if (frame_errs != 0 || tx_first !== 1'b0)
            $display("FAIL basic_framing: errs=%0d tx_at_accept=%b, want 0 0", frame_errs, tx_first);
        else n_pass++;
        n_total++;
        if (busy_n != FRAME) $display("FAIL basic_busy_len: got %0d want %0d", busy_n, FRAME); else n_pass++;
        n_total++;
        if (done_c != FRAME || done_n != 1)
            $display("FAIL basic_done: at %0d count %0d, want %0d 1", done_c, done_n, FRAME);
        else n_pass++;
    endtask

    task automatic test_ignore_busy_vld;
        logic [7:0] exp_b [9] = '{8'hAA, 8'h55, 8'h0B, 8'h11, 8'h02, 8'h34, 8'h06, 8'h00, 8'h2A};
        int bad;
        repeat (20) @(negedge clk);
        start_inputs(12'hB11, 12'h234, 12'h600);
        run_frame(500);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rx_b[i] !== exp_b[i]) $display("FAIL busy_vld_byte%0d: got %h want %h", i, rx_b[i], exp_b[i]);
            else n_pass++;
        end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tlm.busy !== 1'b0 || tlm.TX !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL busy_vld_no_second: %0d active cycles, want 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_a [9] = '{8'hAA, 8'h55, 8'h01, 8'h23, 8'h00, 8'h00, 8'h0A, 8'hBC, 8'h94};
        logic [7:0] exp_f [9] = '{8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'hF0};
        @(negedge clk); start_inputs(12'h123, 12'h000, 12'hABC);
        run_frame(-1);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rx_b[i] !== exp_a[i]) $display("FAIL b2b_first_byte%0d: got %h want %h", i, rx_b[i], exp_a[i]);
            else n_pass++;
        end
        n_total++;
        if (tx_last !== 1'b1 || done_c != FRAME)
            $display("FAIL b2b_first_end: tx=%b done_at=%0d, want 1 %0d", tx_last, done_c, FRAME);
        else n_pass++;
        // Second request raised in the frame_done cycle; all-ones readings give CHK = 0F^FF x3 = F0.
        start_inputs(12'hFFF, 12'hFFF, 12'hFFF);
        run_frame(-1);
        n_total++;
        if (tx_first !== 1'b0 || frame_errs != 0)
            $display("FAIL b2b_no_gap: tx_at_accept=%b errs=%0d, want 0 0", tx_first, frame_errs);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rx_b[i] !== exp_f[i]) $display("FAIL allones_byte%0d: got %h want %h", i, rx_b[i], exp_f[i]);
            else n_pass++;
        end
        n_total++;
        if (busy_n != FRAME || done_c != FRAME)
            $display("FAIL b2b_timing: busy=%0d done_at=%0d, want %0d %0d", busy_n, done_c, FRAME, FRAME);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp_b [9] = '{8'hAA, 8'h55, 8'h0B, 8'h11, 8'h02, 8'h34, 8'h06, 8'h00, 8'h2A};
        repeat (20) @(negedge clk);
        start_inputs(12'h0F0, 12'h00F, 12'h555);
        @(posedge clk); #1; tlm.vld = 1'b0;
        repeat (700) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        n_total++;
        if (tlm.TX !== 1'b1 || tlm.busy !== 1'b0)
            $display("FAIL mid_reset_async: TX=%b busy=%b, want 1 0", tlm.TX, tlm.busy);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        start_inputs(12'hB11, 12'h234, 12'h600);
        run_frame(-1);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rx_b[i] !== exp_b[i]) $display("FAIL post_reset_byte%0d: got %h want %h", i, rx_b[i], exp_b[i]);
            else n_pass++;
        end
        n_total++;
        if (frame_errs != 0 || done_c != FRAME || busy_n != FRAME)
            $display("FAIL post_reset_frame: errs=%0d done_at=%0d busy=%0d, want 0 %0d %0d",
                     frame_errs, done_c, busy_n, FRAME, FRAME);
        else n_pass++;
    endtask

    initial begin
        tlm.batt = 12'd0; tlm.curr = 12'd0; tlm.torque = 12'd0; tlm.vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_ignore_busy_vld();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
